// File: rtl/lstm_seq_ctrl_pkg.sv
// Shared types and default sizing for the LSTM sequence controller and its cell.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lstm_seq_ctrl_pkg;

   localparam int DEF_INPUT_SIZE  = 2;
   localparam int DEF_HIDDEN_SIZE = 2;
   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_MAX_STEPS   = 255;
   localparam int DEF_TIMEOUT     = 1023;

   // One-hot so each state decode is a single flop bit.
   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_START = 5'b00010,
      S_WAIT  = 5'b00100,
      S_OUT   = 5'b01000,
      S_ERR   = 5'b10000
   } seq_state_t;

   // Bits needed to hold the values 0..max_val (at least one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/lstm_seq_ctrl_if.sv
// Bundles the input stream, lstm_cell handshake and output stream of the sequence controller.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready and out_valid/out_ready; the cell side is start/done.
// Ports: master = controller side, slave = upstream/cell/downstream side.
interface lstm_seq_ctrl_if
   import lstm_seq_ctrl_pkg::*;
#(
   parameter int INPUT_SIZE  = DEF_INPUT_SIZE,
   parameter int HIDDEN_SIZE = DEF_HIDDEN_SIZE,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH
);
   // input stream
   logic                                   in_valid;
   logic                                   in_ready;
   logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  in_x;
   logic                                   in_last;
   // lstm_cell handshake
   logic                                   cell_start;
   logic                                   cell_done;
   logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  cell_x;
   logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] cell_h_prev;
   logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] cell_c_prev;
   logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] cell_h;
   logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] cell_c;
   // output stream
   logic                                   out_valid;
   logic                                   out_ready;
   logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] out_h;
   logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] out_c;

   modport master (
      input  in_valid, in_x, in_last,
      output in_ready,
      output cell_start, cell_x, cell_h_prev, cell_c_prev,
      input  cell_done, cell_h, cell_c,
      output out_valid, out_h, out_c,
      input  out_ready
   );

   modport slave (
      output in_valid, in_x, in_last,
      input  in_ready,
      input  cell_start, cell_x, cell_h_prev, cell_c_prev,
      output cell_done, cell_h, cell_c,
      input  out_valid, out_h, out_c,
      output out_ready
   );

endinterface

// File: rtl/lstm_seq_ctrl_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the LIMIT-th one.
// Latency: expired is combinational on the cycle the LIMIT-th enabled cycle is reached.
// Backpressure: none.
// Ports: clk, rst_n (sync, active-low), clr (restart count), en (count this cycle), expired.
module lstm_seq_ctrl_watchdog
   import lstm_seq_ctrl_pkg::*;
#(
   parameter int LIMIT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = cnt_width(LIMIT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != CW'(LIMIT))) begin
         cnt <= cnt + 1'b1;
      end
   end

   // cnt holds the number of enabled cycles already elapsed, so this is the LIMIT-th one.
   assign expired = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/lstm_seq_ctrl.sv
// Sequences one x vector per timestep into lstm_cell, recirculates h/c, emits final h/c.
// Latency: accept -> cell_start next cycle; cell_done -> in_ready (or out_valid) next cycle.
// Backpressure: in_ready only in idle; out_valid holds until out_ready; a hung cell locks to error.
// Ports: clk, rst_n (sync, active-low), bus (master modport of lstm_seq_ctrl_if),
//        step_cnt (saturating steps this sequence), err_timeout (sticky watchdog error).
module lstm_seq_ctrl
   import lstm_seq_ctrl_pkg::*;
#(
   parameter int INPUT_SIZE  = DEF_INPUT_SIZE,
   parameter int HIDDEN_SIZE = DEF_HIDDEN_SIZE,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int MAX_STEPS   = DEF_MAX_STEPS,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  logic                             clk,
   input  logic                             rst_n,
   lstm_seq_ctrl_if.master                  bus,
   output logic [$clog2(MAX_STEPS+1)-1:0]   step_cnt,
   output logic                             err_timeout
);
   localparam int SCW = $clog2(MAX_STEPS + 1);

   seq_state_t state, state_n;

   logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  x_q;
   logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] h_prev_q, c_prev_q, out_h_q, out_c_q;
   logic                                   last_r;
   logic                                   wd_clr, wd_en, wd_expired;

   lstm_seq_ctrl_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n        = state;
      bus.in_ready   = 1'b0;
      bus.cell_start = 1'b0;
      bus.out_valid  = 1'b0;
      wd_clr         = 1'b0;
      wd_en          = 1'b0;
      unique case (state)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_n = S_START;
         end
         S_START: begin
            bus.cell_start = 1'b1;
            wd_clr         = 1'b1;
            state_n        = S_WAIT;
         end
         S_WAIT: begin
            wd_en = 1'b1;
            // A done arriving on the expiry cycle still wins.
            if (bus.cell_done)   state_n = last_r ? S_OUT : S_IDLE;
            else if (wd_expired) state_n = S_ERR;
         end
         S_OUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_n = S_IDLE;
         end
         S_ERR: begin
            state_n = S_ERR;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q         <= '0;
         h_prev_q    <= '0;
         c_prev_q    <= '0;
         out_h_q     <= '0;
         out_c_q     <= '0;
         last_r      <= 1'b0;
         step_cnt    <= '0;
         err_timeout <= 1'b0;
      end else begin
         if ((state == S_IDLE) && bus.in_valid) begin
            x_q    <= bus.in_x;
            last_r <= bus.in_last;
         end
         if ((state == S_WAIT) && bus.cell_done) begin
            h_prev_q <= bus.cell_h;
            c_prev_q <= bus.cell_c;
            if (step_cnt != SCW'(MAX_STEPS)) step_cnt <= step_cnt + 1'b1;
            if (last_r) begin
               out_h_q <= bus.cell_h;
               out_c_q <= bus.cell_c;
            end
         end
         if ((state == S_WAIT) && !bus.cell_done && wd_expired) begin
            err_timeout <= 1'b1;
         end
         // Sequence handed off: the next one starts from zero recurrent state.
         if ((state == S_OUT) && bus.out_ready) begin
            h_prev_q <= '0;
            c_prev_q <= '0;
            step_cnt <= '0;
         end
      end
   end

   assign bus.cell_x      = x_q;
   assign bus.cell_h_prev = h_prev_q;
   assign bus.cell_c_prev = c_prev_q;
   assign bus.out_h       = out_h_q;
   assign bus.out_c       = out_c_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl with a 4-cycle stub cell (h = h_prev + x, c = c_prev + 1).
// Expected final h/c/step_cnt are modelled per input vector and queued, then popped on output.
// Runs with MAX_STEPS=3 and TIMEOUT=16 so saturation and the watchdog are reachable.
module tb_lstm_seq_ctrl;

   typedef logic [1:0][31:0] vec_t;
   typedef struct {
      vec_t h;
      vec_t c;
      int   steps;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] step_cnt;
   logic       err_timeout;

   int   checks = 0;
   int   errors = 0;
   int   n_start = 0;
   exp_t sb[$];
   vec_t m_h = '0;
   vec_t m_c = '0;
   int   m_steps = 0;

   lstm_seq_ctrl_if #(.INPUT_SIZE(2), .HIDDEN_SIZE(2), .DATA_WIDTH(32)) bus ();

   lstm_seq_ctrl #(
      .INPUT_SIZE(2), .HIDDEN_SIZE(2), .DATA_WIDTH(32), .MAX_STEPS(3), .TIMEOUT(16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .step_cnt    (step_cnt),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub cell: computes at the start pulse, raises done for one cycle 4 cycles later.
   bit   stub_en = 1'b1;
   int   stub_cnt = 0;
   vec_t stub_h, stub_c;
   always @(negedge clk) begin
      if (stub_cnt > 0) begin
         stub_cnt = stub_cnt - 1;
         bus.cell_done = (stub_cnt == 0);
         if (stub_cnt == 0) begin
            bus.cell_h = stub_h;
            bus.cell_c = stub_c;
         end
      end else begin
         bus.cell_done = 1'b0;
      end
      if (bus.cell_start === 1'b1 && stub_en) begin
         for (int i = 0; i < 2; i++) begin
            stub_h[i] = bus.cell_h_prev[i] + bus.cell_x[i];
            stub_c[i] = bus.cell_c_prev[i] + 32'd1;
         end
         stub_cnt = 4;
      end
   end

   always @(negedge clk) if (bus.cell_start === 1'b1) n_start++;

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b);
      vec_t v;
      v[0] = a;
      v[1] = b;
      return v;
   endfunction

   task automatic model_clear();
      m_h = '0;
      m_c = '0;
      m_steps = 0;
   endtask

   task automatic model_step(input vec_t x, input bit last);
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         m_h[i] = m_h[i] + x[i];
         m_c[i] = m_c[i] + 32'd1;
      end
      if (m_steps < 3) m_steps++;
      if (last) begin
         e.h = m_h;
         e.c = m_c;
         e.steps = m_steps;
         sb.push_back(e);
         model_clear();
      end
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge (the START cycle).
   task automatic send_x(input vec_t x, input bit last);
      bit ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_x     = x;
      bus.in_last  = last;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (bus.in_ready === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_x_ready got in_ready=0 exp=1 within 200 cycles");
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (ok) model_step(x, last);
   endtask

   task automatic recv_out(input string name);
      bit   ok = 1'b0;
      exp_t e;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (bus.out_valid === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!ok || sb.size() == 0) begin
         errors++;
         $display("FAIL %s_valid got out_valid=%b exp=1 (queued=%0d)", name, bus.out_valid, sb.size());
         bus.out_ready = 1'b0;
         return;
      end
      e = sb.pop_front();
      checks++;
      if (bus.out_h !== e.h) begin
         errors++;
         $display("FAIL %s_out_h got=%h exp=%h", name, bus.out_h, e.h);
      end
      checks++;
      if (bus.out_c !== e.c) begin
         errors++;
         $display("FAIL %s_out_c got=%h exp=%h", name, bus.out_c, e.c);
      end
      checks++;
      if (step_cnt !== 2'(e.steps)) begin
         errors++;
         $display("FAIL %s_step_cnt got=%0d exp=%0d", name, step_cnt, e.steps);
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || step_cnt !== 2'd0 || bus.cell_h_prev !== '0 ||
          bus.cell_c_prev !== '0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_clear got valid=%b step=%0d hprev=%h cprev=%h rdy=%b exp 0/0/0/0/1",
                  name, bus.out_valid, step_cnt, bus.cell_h_prev, bus.cell_c_prev, bus.in_ready);
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.cell_start !== 1'b0 || bus.out_valid !== 1'b0 ||
          err_timeout !== 1'b0 || step_cnt !== 2'd0) begin
         errors++;
         $display("FAIL %s_ctrl got rdy=%b start=%b ovld=%b err=%b step=%0d exp 1/0/0/0/0",
                  name, bus.in_ready, bus.cell_start, bus.out_valid, err_timeout, step_cnt);
      end
      checks++;
      if (bus.cell_x !== '0 || bus.cell_h_prev !== '0 || bus.cell_c_prev !== '0 ||
          bus.out_h !== '0 || bus.out_c !== '0) begin
         errors++;
         $display("FAIL %s_data got x=%h hp=%h cp=%h oh=%h oc=%h exp all 0",
                  name, bus.cell_x, bus.cell_h_prev, bus.cell_c_prev, bus.out_h, bus.out_c);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_seq();
      int s0 = n_start;
      send_x(mk(1, 2), 1'b0);
      send_x(mk(1, 2), 1'b0);
      send_x(mk(1, 2), 1'b1);
      recv_out("basic");
      checks++;
      if (n_start - s0 !== 3) begin
         errors++;
         $display("FAIL basic_starts got=%0d exp=3", n_start - s0);
      end
   endtask

   task automatic test_out_hold();
      bit ok = 1'b0;
      send_x(mk(2, 3), 1'b0);
      send_x(mk(4, 1), 1'b1);
      for (int i = 0; i < 200 && !ok; i++) begin
         if (bus.out_valid === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || sb.size() == 0 || bus.out_h !== sb[0].h) begin
            errors++;
            $display("FAIL hold_cycle%0d got valid=%b out_h=%h exp valid=1 stable h", k,
                     bus.out_valid, bus.out_h);
         end
         @(negedge clk);
      end
      recv_out("hold");
      send_x(mk(5, 5), 1'b1);
      recv_out("fresh");
   endtask

   task automatic test_back_to_back();
      int s0 = n_start;
      int bad = 0;
      bus.in_valid = 1'b1;
      bus.in_x     = mk(7, 8);
      bus.in_last  = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first_ready got=%b exp=1", bus.in_ready);
      end
      @(negedge clk);
      model_step(mk(7, 8), 1'b0);
      bus.in_x    = mk(9, 9);
      bus.in_last = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (bus.in_ready !== 1'b0) bad++;
         if (k == 4) begin
            checks++;
            if (bus.cell_x !== mk(7, 8)) begin
               errors++;
               $display("FAIL b2b_cell_x got=%h exp=%h", bus.cell_x, mk(7, 8));
            end
         end
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL b2b_busy_ready got %0d cycles ready exp=0", bad);
      end
      checks++;
      if (n_start - s0 !== 1) begin
         errors++;
         $display("FAIL b2b_starts_busy got=%0d exp=1", n_start - s0);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready_after_done got=%b exp=1", bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      model_step(mk(9, 9), 1'b1);
      recv_out("b2b");
      checks++;
      if (n_start - s0 !== 2) begin
         errors++;
         $display("FAIL b2b_starts_total got=%0d exp=2", n_start - s0);
      end
   endtask

   task automatic test_saturate();
      for (int k = 0; k < 5; k++) send_x(mk(1, 2), k == 4);
      recv_out("sat");
   endtask

   task automatic test_reset_mid();
      send_x(mk(3, 4), 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      check_all_zero("rst_mid");
      repeat (6) @(negedge clk);
      check_all_zero("rst_late_done");
      send_x(mk(2, 2), 1'b1);
      recv_out("rst_fresh");
   endtask

   task automatic test_timeout();
      int s0;
      int bad = 0;
      stub_en = 1'b0;
      s0 = n_start;
      send_x(mk(1, 1), 1'b0);
      repeat (16) @(negedge clk);
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL to_early got err=%b exp=0", err_timeout);
      end
      @(negedge clk);
      checks++;
      if (err_timeout !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL to_flag got err=%b rdy=%b exp 1/0", err_timeout, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_x     = mk(6, 6);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.in_ready !== 1'b0 || err_timeout !== 1'b1 || bus.out_valid !== 1'b0) bad++;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (bad != 0 || n_start - s0 !== 1) begin
         errors++;
         $display("FAIL to_sticky got bad_cycles=%0d starts=%0d exp 0/1", bad, n_start - s0);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      check_all_zero("to_reset");
      stub_en = 1'b1;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic_seq();
      test_out_hold();
      test_back_to_back();
      test_saturate();
      test_reset_mid();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
